// File: rtl/sdram_rom_loader_if.sv
// Byte stream in, SDRAM port-A write strobe out, for sdram_rom_loader.
// master = stream source / SDRAM side, slave = loader.
interface sdram_rom_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_ready;
  logic [24:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_din;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready,
    input  mem_addr, mem_we, mem_din
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready,
    output mem_addr, mem_we, mem_din
  );
endinterface

// File: rtl/sdram_rom_loader.sv
// ROM image loader: strips a file header, buffers payload bytes and
// writes them into SDRAM one byte per clkref period.
module sdram_rom_loader #(
  parameter logic [24:0] BASE_ADDR  = 25'h0000000,
  parameter int          HDR_SKIP   = 16,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clkref,
  input  logic               start,
  sdram_rom_loader_if.slave  bus,
  output logic               busy,
  output logic               done,
  output logic [24:0]        byte_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [15:0] HDR_LD = 16'(HDR_SKIP);
  localparam logic [AW:0] FULL_N = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SKIP,
    S_LOAD,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [7:0]    fifo [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          clkref_q;
  logic [15:0]   hdr_cnt;
  logic [24:0]   wr_idx, idx_nx;
  logic          mem_we_r;
  logic [24:0]   mem_addr_r;
  logic [7:0]    mem_din_r;
  logic          in_rdy;

  logic fe, full, empty, go, xfer, push, pop;

  assign fe     = clkref_q & ~clkref;
  assign full   = (count == FULL_N);
  assign empty  = (count == '0);
  assign go     = start & ((state == S_IDLE) | (state == S_DONE));
  assign xfer   = bus.in_valid & in_rdy;
  assign push   = xfer & (state == S_LOAD);
  assign pop    = fe & ~empty;
  // a completed slot advances the index before the next address is formed
  assign idx_nx = mem_we_r ? wr_idx + 25'd1 : wr_idx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    in_rdy   = 1'b0;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (start)
          state_nx = (HDR_SKIP == 0) ? S_LOAD : S_SKIP;
      end
      S_SKIP: begin
        in_rdy = 1'b1;
        if (xfer) begin
          if (bus.in_last)            state_nx = S_DONE;
          else if (hdr_cnt == 16'd1)  state_nx = S_LOAD;
        end
      end
      S_LOAD: begin
        in_rdy = ~full;
        if (xfer && bus.in_last) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        if (empty && !mem_we_r) state_nx = S_DONE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clkref_q <= 1'b0;
    end else begin
      clkref_q <= clkref;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hdr_cnt <= '0;
    end else if (go) begin
      hdr_cnt <= HDR_LD;
    end else if (xfer && state == S_SKIP) begin
      hdr_cnt <= hdr_cnt - 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= bus.in_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // mem_* only change on the clkref fall, so each write spans a full high slot
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_idx     <= '0;
      mem_we_r   <= 1'b0;
      mem_addr_r <= BASE_ADDR;
      mem_din_r  <= '0;
    end else begin
      if (go)
        wr_idx <= '0;
      else if (fe && mem_we_r)
        wr_idx <= idx_nx;
      if (fe) begin
        mem_we_r <= ~empty;
        if (!empty) begin
          mem_din_r  <= fifo[rd_ptr];
          mem_addr_r <= BASE_ADDR + idx_nx;
        end
      end
    end
  end

  assign bus.in_ready = in_rdy;
  assign bus.mem_we   = mem_we_r;
  assign bus.mem_addr = mem_addr_r;
  assign bus.mem_din  = mem_din_r;

  assign busy = (state == S_SKIP) | (state == S_LOAD) | (state == S_DRAIN);
  assign done = (state == S_DONE);
  assign byte_count = wr_idx;

endmodule

// File: tb/tb_sdram_rom_loader.sv
// Scoreboard bench for sdram_rom_loader: two instances, the second
// with a base address near the top of the 25-bit space and no header.
module tb_sdram_rom_loader;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic clkref = 1'b0;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  logic sel = 1'b0;
  logic s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic s_last = 1'b0;

  logic busy_a, done_a, busy_b, done_b;
  logic [24:0] cnt_a, cnt_b;

  sdram_rom_loader_if ifa ();
  sdram_rom_loader_if ifb ();

  assign ifa.in_valid = s_valid & ~sel;
  assign ifa.in_data  = s_data;
  assign ifa.in_last  = s_last;
  assign ifb.in_valid = s_valid & sel;
  assign ifb.in_data  = s_data;
  assign ifb.in_last  = s_last;

  sdram_rom_loader dut_a (
    .clk(clk), .reset_n(reset_n), .clkref(clkref), .start(start_a),
    .bus(ifa.slave), .busy(busy_a), .done(done_a), .byte_count(cnt_a)
  );

  sdram_rom_loader #(
    .BASE_ADDR(25'h1FFFFFE), .HDR_SKIP(0), .FIFO_DEPTH(4)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .clkref(clkref), .start(start_b),
    .bus(ifb.slave), .busy(busy_b), .done(done_b), .byte_count(cnt_b)
  );

  logic in_ready_m, mem_we_m, busy_m, done_m;
  logic [24:0] mem_addr_m, cnt_m;
  logic [7:0] mem_din_m;
  assign in_ready_m = sel ? ifb.in_ready : ifa.in_ready;
  assign mem_we_m   = sel ? ifb.mem_we   : ifa.mem_we;
  assign mem_addr_m = sel ? ifb.mem_addr : ifa.mem_addr;
  assign mem_din_m  = sel ? ifb.mem_din  : ifa.mem_din;
  assign busy_m     = sel ? busy_b : busy_a;
  assign done_m     = sel ? done_b : done_a;
  assign cnt_m      = sel ? cnt_b  : cnt_a;

  always #5 clk = ~clk;

  // clkref: 4 clk high, 4 clk low, changing on the falling clk edge
  int rc = 0;
  always @(negedge clk) begin
    rc = (rc + 1) % 8;
    clkref = (rc >= 4);
  end

  int total = 0;
  int passed = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  logic [32:0] exp_q[$];
  logic [32:0] e;
  logic slot_open = 1'b0;
  logic [24:0] cap_a;
  logic [7:0] cap_d;
  int run = 0, max_run = 0, slots = 0;
  logic stall_seen = 1'b0, we_seen = 1'b0;

  // slot monitor: a write is seen at clkref rise and must hold until the fall
  always @(clkref) begin
    #1;
    if (!reset_n) begin
      slot_open = 1'b0;
      run = 0;
    end else if (clkref) begin
      if (mem_we_m) begin
        slot_open = 1'b1;
        cap_a = mem_addr_m;
        cap_d = mem_din_m;
        slots++;
        run++;
        if (run > max_run) max_run = run;
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_write: addr %h data %h, none queued",
                   cap_a, cap_d);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", 32'(cap_a), 32'(e[32:8]));
          chk("wr_data", 32'(cap_d), 32'(e[7:0]));
        end
      end else begin
        run = 0;
      end
    end else begin
      if (slot_open) begin
        chk("hold_we", 32'(mem_we_m), 32'd1);
        chk("hold_addr", 32'(mem_addr_m), 32'(cap_a));
        chk("hold_data", 32'(mem_din_m), 32'(cap_d));
      end
      slot_open = 1'b0;
    end
  end

  always @(negedge clk) begin
    #2;
    if (s_valid && !in_ready_m && busy_m) stall_seen = 1'b1;
    if (mem_we_m) we_seen = 1'b1;
  end

  task automatic send(input logic [7:0] b, input logic last);
    int t = 0;
    s_valid = 1'b1;
    s_data = b;
    s_last = last;
    while (!in_ready_m && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      total++;
      $display("FAIL send_timeout: in_ready %b required 1", in_ready_m);
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic payload(input logic [7:0] b, input logic last,
                         input logic [24:0] addr);
    exp_q.push_back({addr, b});
    send(b, last);
  endtask

  task automatic header(input int n);
    for (int i = 0; i < n; i++) send(8'(8'hE0 + i), 1'b0);
  endtask

  task automatic pulse_start();
    slots = 0;
    max_run = 0;
    stall_seen = 1'b0;
    we_seen = 1'b0;
    if (sel) start_b = 1'b1;
    else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int t = 0;
    while (!done_m && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk(nm, 32'(done_m), 32'd1);
    chk({nm, "_busy"}, 32'(busy_m), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(ifa.in_ready), 32'd0);
    chk("rst_din", 32'(ifa.mem_din), 32'd0);
    reset_n = 1'b1;

    // idle with clkref running
    for (int i = 0; i < 5; i++) begin
      repeat (8) @(negedge clk);
      chk("idle_we", 32'(ifa.mem_we), 32'd0);
      chk("idle_addr", 32'(ifa.mem_addr), 32'd0);
    end
    chk("idle_busy", 32'(busy_a), 32'd0);
    chk("idle_done", 32'(done_a), 32'd0);
    chk("idle_cnt", 32'(cnt_a), 32'd0);

    // header + 3 payload bytes
    pulse_start();
    chk("start_busy", 32'(busy_a), 32'd1);
    header(16);
    payload(8'hA0, 1'b0, 25'd0);
    payload(8'hA1, 1'b0, 25'd1);
    payload(8'hA2, 1'b1, 25'd2);
    wait_done("t3_done");
    chk("t3_cnt", 32'(cnt_a), 32'd3);
    chk("t3_slots", 32'(slots), 32'd3);
    chk("t3_run", 32'(max_run), 32'd3);
    chk("t3_q_empty", 32'(exp_q.size()), 32'd0);

    // 10-byte burst through the 4-deep FIFO
    pulse_start();
    chk("restart_done", 32'(done_a), 32'd0);
    header(16);
    for (int i = 0; i < 10; i++)
      payload(8'(8'h10 + i), 1'(i == 9), 25'(i));
    wait_done("t10_done");
    chk("t10_cnt", 32'(cnt_a), 32'd10);
    chk("t10_slots", 32'(slots), 32'd10);
    chk("t10_run", 32'(max_run), 32'd10);
    chk("t10_stall", 32'(stall_seen), 32'd1);
    chk("t10_q_empty", 32'(exp_q.size()), 32'd0);

    // stream ends inside the header
    pulse_start();
    for (int i = 0; i < 5; i++) send(8'(i), 1'(i == 4));
    wait_done("hdr_last_done");
    chk("hdr_last_cnt", 32'(cnt_a), 32'd0);
    chk("hdr_last_we", 32'(we_seen), 32'd0);

    // reset during the third of six slots
    pulse_start();
    header(16);
    for (int i = 0; i < 6; i++)
      payload(8'(8'h50 + i), 1'(i == 5), 25'(i));
    begin
      int t = 0;
      while (!(cnt_a == 25'd2 && ifa.mem_we) && t < 500) begin
        @(negedge clk);
        t++;
      end
      chk("mid_reached", 32'(cnt_a), 32'd2);
    end
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_we", 32'(ifa.mem_we), 32'd0);
    chk("mid_rst_addr", 32'(ifa.mem_addr), 32'd0);
    chk("mid_rst_din", 32'(ifa.mem_din), 32'd0);
    chk("mid_rst_busy", 32'(busy_a), 32'd0);
    chk("mid_rst_done", 32'(done_a), 32'd0);
    chk("mid_rst_cnt", 32'(cnt_a), 32'd0);
    chk("mid_rst_rdy", 32'(ifa.in_ready), 32'd0);
    exp_q.delete();
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    pulse_start();
    header(16);
    payload(8'h60, 1'b0, 25'd0);
    payload(8'h61, 1'b1, 25'd1);
    wait_done("reload_done");
    chk("reload_cnt", 32'(cnt_a), 32'd2);
    chk("reload_q_empty", 32'(exp_q.size()), 32'd0);

    // address wrap on the second instance
    sel = 1'b1;
    @(negedge clk);
    pulse_start();
    payload(8'hC0, 1'b0, 25'h1FFFFFE);
    payload(8'hC1, 1'b0, 25'h1FFFFFF);
    payload(8'hC2, 1'b1, 25'h0000000);
    wait_done("wrap_done");
    chk("wrap_cnt", 32'(cnt_b), 32'd3);
    chk("wrap_q_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
